// File: rtl/rom_loader.sv
// Boot loader: parses SYNC, 16-bit length and N big-endian words from a byte stream into ROM,
// holding the core in reset until the load completes. Optional trailer checksum: ROM_LOADER_CHKSUM_EN.
module rom_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        rom_we,
  output logic [15:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        core_reset_n,
  output logic        rom_en,
  output logic        ram_cen,
  output logic        done,
  output logic        err
);

`ifdef ROM_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHK, DONE, ERR} state_t;
  localparam state_t FINAL_ST = CHK;
`else
  typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA_H, DATA_L, DONE, ERR} state_t;
  localparam state_t FINAL_ST = DONE;
`endif

  state_t      state_q, state_d;
  logic        rx_ready_q, rx_ready_d;
  logic        rom_we_q, rom_we_d;
  logic [15:0] rom_addr_q, rom_addr_d;
  logic [15:0] rom_wdata_q, rom_wdata_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
`ifdef ROM_LOADER_CHKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif
  logic        accept;

  always_comb begin
    accept      = rx_valid && rx_ready_q;
    state_d     = state_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    len_d       = len_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
`ifdef ROM_LOADER_CHKSUM_EN
    chk_d       = chk_q;
`endif
    // restart outranks a concurrent byte; an already-issued rom_we is a flop and still completes
    if (restart) begin
      state_d     = IDLE;
      rom_addr_d  = BASE_ADDR;
      rom_wdata_d = '0;
      len_d       = '0;
      idx_d       = '0;
      hi_d        = '0;
`ifdef ROM_LOADER_CHKSUM_EN
      chk_d       = '0;
`endif
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = LEN_H;
        end
        LEN_H: begin
          len_d[15:8] = rx_data;
          state_d     = LEN_L;
        end
        LEN_L: begin
          len_d[7:0] = rx_data;
          state_d    = ({len_q[15:8], rx_data} == 16'h0000) ? FINAL_ST : DATA_H;
        end
        DATA_H: begin
          hi_d    = rx_data;
          state_d = DATA_L;
`ifdef ROM_LOADER_CHKSUM_EN
          chk_d   = chk_q + rx_data;
`endif
        end
        DATA_L: begin
          rom_we_d    = 1'b1;
          rom_addr_d  = BASE_ADDR + idx_q;
          rom_wdata_d = {hi_q, rx_data};
          idx_d       = idx_q + 16'd1;
          state_d     = (idx_q + 16'd1 == len_q) ? FINAL_ST : DATA_H;
`ifdef ROM_LOADER_CHKSUM_EN
          chk_d       = chk_q + rx_data;
`endif
        end
`ifdef ROM_LOADER_CHKSUM_EN
        CHK: begin
          state_d = (rx_data == chk_q) ? DONE : ERR;
        end
`endif
        default: ;
      endcase
    end
    case (state_d)
      DONE, ERR: rx_ready_d = 1'b0;
      default:   rx_ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= BASE_ADDR;
      rom_wdata_q <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
`ifdef ROM_LOADER_CHKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
`ifdef ROM_LOADER_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign rom_we       = rom_we_q;
  assign rom_addr     = rom_addr_q;
  assign rom_wdata    = rom_wdata_q;
  assign done         = (state_q == DONE);
  assign core_reset_n = done;
  assign rom_en       = done;
  assign ram_cen      = done;
`ifdef ROM_LOADER_CHKSUM_EN
  assign err          = (state_q == ERR);
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: byte-position frame model checked every cycle, plus literal write logs.
// Two instances share stimulus: BASE_ADDR 0000 and FFFF (address wrap).
module tb_rom_loader;
  localparam logic [15:0] BASE_A = 16'h0000;
  localparam logic [15:0] BASE_B = 16'hFFFF;
  localparam logic [7:0]  SYNC   = 8'hA5;
`ifdef ROM_LOADER_CHKSUM_EN
  localparam int CHK_ON = 1;
`else
  localparam int CHK_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        restart = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        rx_ready, rom_we, core_reset_n, rom_en, ram_cen, done, err;
  logic [15:0] rom_addr, rom_wdata;
  logic        rx_ready_b, rom_we_b, core_reset_n_b, rom_en_b, ram_cen_b, done_b, err_b;
  logic [15:0] rom_addr_b, rom_wdata_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rom_loader #(.SYNC_BYTE(SYNC), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .restart(restart), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .core_reset_n(core_reset_n), .rom_en(rom_en), .ram_cen(ram_cen), .done(done), .err(err)
  );

  rom_loader #(.SYNC_BYTE(SYNC), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .restart(restart), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready_b), .rom_we(rom_we_b), .rom_addr(rom_addr_b), .rom_wdata(rom_wdata_b),
    .core_reset_n(core_reset_n_b), .rom_en(rom_en_b), .ram_cen(ram_cen_b), .done(done_b),
    .err(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tracks bytes accepted after SYNC by position; result 0=loading, 1=done, 2=error
  logic        m_ready, m_we, m_fresh, m_in_frame;
  logic [15:0] m_word, m_wdata, m_len;
  logic [7:0]  m_sum;
  int          m_result;
  logic [7:0]  m_bytes[$];

  task automatic model_clear();
    m_we = 1'b0; m_fresh = 1'b1; m_in_frame = 1'b0;
    m_word = '0; m_wdata = '0; m_len = '0; m_sum = '0; m_result = 0;
    m_bytes.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n, total;
    if (!m_in_frame) begin
      if (b == SYNC) m_in_frame = 1'b1;
      return;
    end
    m_bytes.push_back(b);
    n = m_bytes.size();
    if (n == 2) m_len = {m_bytes[0], m_bytes[1]};
    if (n < 2) return;
    total = 2 + 2 * int'(m_len) + CHK_ON;
    if (n > 2 && n <= 2 + 2 * int'(m_len)) begin
      m_sum = m_sum + b;
      if (n % 2 == 0) begin
        m_we    = 1'b1;
        m_fresh = 1'b0;
        m_word  = 16'((n - 2) / 2 - 1);
        m_wdata = {m_bytes[n-2], b};
      end
    end
    if (n == total) m_result = (CHK_ON == 1 && b != m_sum) ? 2 : 1;
  endtask

  initial begin
    model_clear();
    m_ready = 1'b0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_clear();
        m_ready = 1'b0;
      end else begin
        logic acc;
        acc  = rx_valid && m_ready;
        m_we = 1'b0;
        if (restart) model_clear();
        else if (acc && m_result == 0) model_byte(rx_data);
        m_ready = (m_result == 0);
      end
    end
  end

  logic [31:0] log_a[$];
  logic [15:0] log_b[$];
  logic [15:0] exp_a, exp_b;

  // Per-cycle comparison against the model; address/data only where they are defined
  initial begin
    forever begin
      @(negedge clk);
      chk("rx_ready", rx_ready, m_ready);
      chk("rx_ready_b", rx_ready_b, m_ready);
      chk("rom_we", rom_we, m_we);
      chk("rom_we_b", rom_we_b, m_we);
      if (m_we || m_fresh) begin
        exp_a = m_fresh ? BASE_A : 16'(BASE_A + m_word);
        exp_b = m_fresh ? BASE_B : 16'(BASE_B + m_word);
        chk("rom_addr", rom_addr, exp_a);
        chk("rom_addr_b", rom_addr_b, exp_b);
        chk("rom_wdata", rom_wdata, m_fresh ? 16'h0000 : m_wdata);
      end
      chk("done", done, m_result == 1);
      chk("core_reset_n", core_reset_n, m_result == 1);
      chk("rom_en", rom_en, m_result == 1);
      chk("ram_cen", ram_cen, m_result == 1);
      chk("done_b", done_b, m_result == 1);
      chk("err", err, m_result == 2);
      if (rom_we) log_a.push_back({rom_addr, rom_wdata});
      if (rom_we_b) log_b.push_back(rom_addr_b);
    end
  end

  function automatic logic [31:0] get_a(input int i);
    return (i < log_a.size()) ? log_a[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [15:0] get_b(input int i);
    return (i < log_b.size()) ? log_b[i] : 16'hxxxx;
  endfunction

  task automatic clear_logs();
    log_a.delete();
    log_b.delete();
  endtask

  task automatic drive(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    clear_logs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 1'b0);
    chk({tag, "_rom_we"}, rom_we, 1'b0);
    chk({tag, "_rom_addr"}, rom_addr, BASE_A);
    chk({tag, "_rom_addr_b"}, rom_addr_b, BASE_B);
    chk({tag, "_rom_wdata"}, rom_wdata, 16'h0000);
    chk({tag, "_core_reset_n"}, core_reset_n, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2 check_reset_values("reset");
    #19 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_first_edge", rx_ready, 1'b1);

    // Two-word frame: writes 1234@0000 then ABCD@0001
    drive(8'hA5); drive(8'h00); drive(8'h02);
    drive(8'h12); drive(8'h34); drive(8'hAB); drive(8'hCD);
    chk("w2_we", rom_we, 1'b1);
    chk("w2_addr", rom_addr, 16'h0001);
    chk("w2_data", rom_wdata, 16'hABCD);
`ifdef ROM_LOADER_CHKSUM_EN
    chk("w2_not_done_before_trailer", done, 1'b0);
    drive(8'hBE);
`endif
    chk("frame1_done", done, 1'b1);
    chk("frame1_core_reset_n", core_reset_n, 1'b1);
    chk("frame1_rom_en", rom_en, 1'b1);
    chk("frame1_ram_cen", ram_cen, 1'b1);
    idle(2);
    drive(8'hA5);
    idle(1);
    chk("frame1_done_hold", done, 1'b1);
    chk("frame1_err", err, 1'b0);
    chk("frame1_nwr", log_a.size(), 2);
    chk("frame1_w0", get_a(0), {16'h0000, 16'h1234});
    chk("frame1_w1", get_a(1), {16'h0001, 16'hABCD});
    chk("frame1_b0", get_b(0), 16'hFFFF);
    chk("frame1_b1", get_b(1), 16'h0000);

    // Leading junk then a zero-length frame: no writes, done
    do_restart();
    chk("restart_done_low", done, 1'b0);
    drive(8'h00); drive(8'hFF); drive(8'hA5); drive(8'h00); drive(8'h00);
    if (CHK_ON == 1) drive(8'h00);
    chk("zero_len_done", done, 1'b1);
    chk("zero_len_nwr", log_a.size(), 0);

    // Frame with idle gaps between bytes
    do_restart();
    drive(8'hA5); idle(2); drive(8'h00); drive(8'h01); idle(1); drive(8'h55); drive(8'h66);
    if (CHK_ON == 1) drive(8'hBB);
    idle(1);
    chk("gap_done", done, 1'b1);
    chk("gap_nwr", log_a.size(), 1);
    chk("gap_w0", get_a(0), {16'h0000, 16'h5566});
    chk("gap_b0", get_b(0), 16'hFFFF);

    // restart with a byte presented in DATA_L: byte dropped, reset-like outputs, ready
    do_restart();
    drive(8'hA5); drive(8'h00); drive(8'h02); drive(8'h12); drive(8'h34); drive(8'hAB);
    restart = 1'b1; rx_valid = 1'b1; rx_data = 8'hCD;
    @(posedge clk); #1;
    restart = 1'b0; rx_valid = 1'b0;
    chk("rs_ready", rx_ready, 1'b1);
    chk("rs_we", rom_we, 1'b0);
    chk("rs_addr", rom_addr, 16'h0000);
    chk("rs_wdata", rom_wdata, 16'h0000);
    chk("rs_done", done, 1'b0);
    chk("rs_nwr", log_a.size(), 1);
    clear_logs();
    drive(8'hA5); drive(8'h00); drive(8'h01); drive(8'hBE); drive(8'hEF);
    if (CHK_ON == 1) drive(8'hAD);
    idle(1);
    chk("rs_reload_done", done, 1'b1);
    chk("rs_reload_nwr", log_a.size(), 1);
    chk("rs_reload_w0", get_a(0), {16'h0000, 16'hBEEF});
    chk("rs_reload_b0", get_b(0), 16'hFFFF);

    // restart in the same cycle as a pending write strobe
    do_restart();
    drive(8'hA5); drive(8'h00); drive(8'h03); drive(8'h11); drive(8'h22);
    restart = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
    chk("pend_we_kept", rom_we, 1'b1);
    chk("pend_data", rom_wdata, 16'h1122);
    @(posedge clk); #1;
    restart = 1'b0; rx_valid = 1'b0;
    chk("pend_we_after", rom_we, 1'b0);
    chk("pend_ready", rx_ready, 1'b1);
    chk("pend_nwr", log_a.size(), 1);
    chk("pend_w0", get_a(0), {16'h0000, 16'h1122});

    // Asynchronous reset in DATA_H, then a full reload from BASE_ADDR
    do_restart();
    drive(8'hA5); drive(8'h00); drive(8'h02); drive(8'h01); drive(8'h02);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async");
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("async_ready", rx_ready, 1'b1);
    clear_logs();
    drive(8'hA5); drive(8'h00); drive(8'h02);
    drive(8'h12); drive(8'h34); drive(8'hAB); drive(8'hCD);
    if (CHK_ON == 1) drive(8'hBE);
    idle(1);
    chk("async_reload_done", done, 1'b1);
    chk("async_reload_nwr", log_a.size(), 2);
    chk("async_reload_w0", get_a(0), {16'h0000, 16'h1234});
    chk("async_reload_w1", get_a(1), {16'h0001, 16'hABCD});
    chk("async_reload_b1", get_b(1), 16'h0000);

`ifdef ROM_LOADER_CHKSUM_EN
    do_restart();
    drive(8'hA5); drive(8'h00); drive(8'h01); drive(8'h10); drive(8'h20); drive(8'h30);
    idle(1);
    chk("cs_good_done", done, 1'b1);
    chk("cs_good_err", err, 1'b0);
    chk("cs_good_w0", get_a(0), {16'h0000, 16'h1020});
    do_restart();
    drive(8'hA5); drive(8'h00); drive(8'h01); drive(8'h10); drive(8'h20); drive(8'h31);
    idle(1);
    chk("cs_bad_err", err, 1'b1);
    chk("cs_bad_done", done, 1'b0);
    chk("cs_bad_core_reset_n", core_reset_n, 1'b0);
    chk("cs_bad_ready", rx_ready, 1'b0);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
